x_sipo32: RTL

X_SIPO32 -- requirements
Module: x_sipo32

---
 rtl/x_sipo32_pkg.sv | 39 +++
 rtl/x_sipo32_cnt.sv | 42 ++++
 rtl/x_sipo32.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/x_sipo32_pkg.sv
// -----------------------------------------------------------------------------
// x_sipo32_pkg
// Shared constants and types for the 32-bit serial-in / parallel-out
// deserialiser.
//   WIDTH      : parallel data width (32)
//   WORD_BITS  : serial bits per word (32, or 33 with the parity bit)
//   CNT_W      : width of the per-word bit counter
//   CNT_LAST   : counter value of the final bit of a word
//   state_t    : SHIFT (collecting bits) / FULL (completed word held, O busy)
// Optional feature macro: X_SIPO32_PARITY_EN (adds one odd-parity bit per word).
// -----------------------------------------------------------------------------
package x_sipo32_pkg;

    localparam int WIDTH = 32;

`ifdef X_SIPO32_PARITY_EN
    localparam int WORD_BITS = WIDTH + 1;
`else
    localparam int WORD_BITS = WIDTH;
`endif

    localparam int CNT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);

    typedef enum logic [0:0] {
        SHIFT = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Destination bit of the data bit counted by cnt. Only called for data
    // bits, so the low five counter bits are always a valid 0..31 index.
    function automatic logic [4:0] bit_index(input logic [CNT_W-1:0] cnt,
                                             input bit msb_first);
        logic [4:0] idx;
        idx = cnt[4:0];
        return msb_first ? (5'd31 - idx) : idx;
    endfunction

endpackage

// File: rtl/x_sipo32_cnt.sv
// -----------------------------------------------------------------------------
// x_sipo32_cnt
// Per-word bit counter with terminal-count decode.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (counter to 0)
//   inc   : a bit was accepted this cycle (already qualified by clock enable)
//   cnt   : bits accepted so far in the current word
//   last  : cnt is at the final bit of a word; the next inc wraps to 0
// Word length follows X_SIPO32_PARITY_EN through the package constants.
// -----------------------------------------------------------------------------
module x_sipo32_cnt
    import x_sipo32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == CNT_LAST);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/x_sipo32.sv
// -----------------------------------------------------------------------------
// x_sipo32
// Serial-in / parallel-out converter with valid/ready handshakes on both sides.
// Parameters:
//   MSB_FIRST : 0 = first bit of a word lands in O[0], 1 = in O[31]
//   INIT      : reset value of O
// Ports:
//   CLK       : clock, rising edge
//   RST_N     : synchronous active-low reset (overrides CE)
//   CE        : clock enable; low holds all state, no handshake completes
//   SI        : serial data bit
//   SI_VALID  : SI carries a bit
//   SI_READY  : bit is accepted this cycle (decoded from state only)
//   O         : assembled word (registered)
//   O_VALID   : O holds an undelivered word (registered)
//   O_READY   : consumer takes O this cycle
//   PERR      : (X_SIPO32_PARITY_EN only) odd-parity error, loads with O
// Optional feature macro: X_SIPO32_PARITY_EN.
// -----------------------------------------------------------------------------
module x_sipo32
    import x_sipo32_pkg::*;
#(
    parameter bit               MSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] INIT      = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             SI,
    input  logic             SI_VALID,
    output logic             SI_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY
`ifdef X_SIPO32_PARITY_EN
    ,
    output logic             PERR
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_d;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_d;
    logic             o_valid_q;
    logic             o_valid_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             accept;
    logic             deliver;
    logic             data_bit;
    logic             load;
    logic [WIDTH-1:0] word_next;

    assign SI_READY = (state_q == SHIFT);
    assign accept   = CE & SI_VALID & SI_READY;
    assign deliver  = CE & o_valid_q & O_READY;

    x_sipo32_cnt u_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (accept),
        .cnt   (cnt),
        .last  (cnt_last)
    );

`ifdef X_SIPO32_PARITY_EN
    // The final counted bit of a word is the parity bit, not data.
    assign data_bit = ~cnt_last;
`else
    assign data_bit = 1'b1;
`endif

    always_comb begin
        // The assembly register doubles as the held word while in FULL; no
        // bits are accepted there, so it stays intact until delivered. Stale
        // bits left from the previous word are all overwritten before the
        // next completion.
        word_next = asm_q;
        if (accept && data_bit) begin
            word_next[bit_index(cnt, MSB_FIRST)] = SI;
        end
        asm_d   = word_next;
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            SHIFT: begin
                if (accept && cnt_last) begin
                    // O is free if empty or being taken on this same edge.
                    if (!o_valid_q || deliver) begin
                        load = 1'b1;
                    end else begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (deliver) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            default: state_d = SHIFT;
        endcase
        o_d       = load ? word_next : o_q;
        o_valid_d = load | (o_valid_q & ~deliver);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= SHIFT;
            asm_q     <= '0;
            o_q       <= INIT;
            o_valid_q <= 1'b0;
        end else if (CE) begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign O       = o_q;
    assign O_VALID = o_valid_q;

`ifdef X_SIPO32_PARITY_EN
    logic par_q;
    logic par_d;
    logic perr_q;
    logic perr_d;

    always_comb begin
        // In FULL nothing is accepted, so par_d is the held parity bit; in
        // SHIFT on completion it is the parity bit arriving now.
        par_d = par_q;
        if (accept && !data_bit) begin
            par_d = SI;
        end
        // Odd parity: the 33 bits must XOR to 1.
        perr_d = load ? ~(^word_next ^ par_d) : perr_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else if (CE) begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign PERR = perr_q;
`endif

endmodule
